// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl_if
// Brief    : Host/mux-side signal bundle for the UART transmit controller.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART frame sequencer (start, LSB-first data, parity, stop) that
//            drives the TX output mux select, data bit and parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    uart_tx_ctrl_if.slave      bus
);
    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [1:0] c_MUX_START  = 2'b00;
    localparam logic [1:0] c_MUX_STOP   = 2'b01;
    localparam logic [1:0] c_MUX_DATA   = 2'b10;
    localparam logic [1:0] c_MUX_PARITY = 2'b11;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_accept;
    logic [1:0]            w_mux_sel;
    logic                  w_busy;
    logic                  w_ser_data;

    assign w_accept = (r_state == S_IDLE) && bus.DATA_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.DATA_VALID) w_next = S_START;
            S_START:  w_next = S_DATA;
            S_DATA:   if (r_cnt == c_LAST) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Frame config and parity are captured once so host changes mid-frame are invisible.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= bus.P_DATA;
                r_par_en  <= bus.PAR_EN;
                r_par_bit <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end
            if (r_state == S_DATA) begin
                r_shift <= r_shift >> 1;
                if (r_cnt != c_LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_mux_sel  = c_MUX_STOP;
        w_busy     = 1'b1;
        w_ser_data = 1'b0;
        case (r_state)
            S_IDLE:   w_busy = 1'b0;
            S_START:  w_mux_sel = c_MUX_START;
            S_DATA: begin
                w_mux_sel  = c_MUX_DATA;
                w_ser_data = r_shift[0];
            end
            S_PARITY: w_mux_sel = c_MUX_PARITY;
            S_STOP:   w_mux_sel = c_MUX_STOP;
            default:  w_busy = 1'b0;
        endcase
    end

    assign bus.mux_sel  = w_mux_sel;
    assign bus.busy     = w_busy;
    assign bus.ser_data = w_ser_data;
    assign bus.par_bit  = r_par_bit;
endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that sits directly upstream of the TX output multiplexer.
- Accepts a parallel byte with a valid strobe.
- Sequences the frame: start, data (LSB first), optional parity, stop.
- Drives the multiplexer select, serial data bit and parity bit, one bit per CLK cycle. CLK is the baud-rate clock.
- Reports busy back to the host.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
CLK  input  1  baud-rate clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel data; sampled only on acceptance
DATA_VALID  input  1  request to send P_DATA
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
mux_sel  output  2  00 start, 01 stop/idle, 10 data, 11 parity
ser_data  output  1  current data bit (LSB first)
par_bit  output  1  parity of latched data
busy  output  1  frame in progress; new requests ignored

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous and active-high (RST). Reset overrides everything, including a request in the same cycle.
- Reset values: state IDLE, mux_sel=01, ser_data=0, par_bit=0, busy=0, bit counter=0, shift register=0.
- Output timing: Moore style. mux_sel and busy decode from the state register only; no combinational path from any input to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: occurs when state==IDLE and DATA_VALID==1 at a rising edge.
  - Latch P_DATA into the shift register, and PAR_EN/PAR_TYP into config registers.
  - Compute par_bit = ^P_DATA (even) or ~^P_DATA (odd).
  - Next state: START.
- DATA_VALID in any state other than IDLE is ignored. Changes to P_DATA, PAR_EN or PAR_TYP after acceptance have no effect on the frame in flight.
- START: mux_sel=00, busy=1, 1 cycle, then DATA with counter=0.
- DATA: mux_sel=10, busy=1, ser_data=shift_reg[0].
  - Each cycle: shift right and increment counter.
  - After DATA_WIDTH cycles (counter==DATA_WIDTH-1): next state is PARITY if latched PAR_EN=1, else STOP.
- PARITY: mux_sel=11, busy=1, 1 cycle, then STOP. par_bit holds its value until the next acceptance.
- STOP: mux_sel=01, busy=1, 1 cycle, then IDLE.
- IDLE: mux_sel=01 (line high via stop bit), busy=0.
- Frame length (busy high): 1 + DATA_WIDTH + PAR_EN + 1 cycles. Latency from the accepting edge to the first start-bit cycle: 1 cycle.
- Back-to-back: DATA_VALID held high produces frames separated by exactly one IDLE cycle (acceptance happens in that IDLE cycle).
- Reset asserted mid-frame: next cycle is IDLE with reset values, and the partial frame is abandoned. A DATA_VALID asserted in the reset cycle is not accepted.
- Counter width: clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, DATA_VALID=0 -> mux_sel=01, busy=0, ser_data=0, par_bit=0 for 20 cycles.
- No parity: P_DATA=0xA5, PAR_EN=0, DATA_VALID pulsed 1 cycle.
  - Next 10 cycles mux_sel = 00, 10x8, 01.
  - ser_data during DATA = 1,0,1,0,0,1,0,1.
  - busy high exactly 10 cycles, then mux_sel=01, busy=0.
- Even and odd parity: 0xA5 with PAR_EN=1.
  - PAR_TYP=0 -> PARITY cycle with par_bit=0; PAR_TYP=1 -> par_bit=1.
  - Frame is 11 cycles, mux_sel sequence 00, 10x8, 11, 01.
- Ignore while busy: accept 0x3C, then mid-DATA pulse DATA_VALID with P_DATA=0xFF and toggle PAR_TYP -> serial bits remain 0,0,1,1,1,1,0,0; no second frame starts.
- Back-to-back: DATA_VALID held high, P_DATA=0x01 then 0x80 -> two 10-cycle frames separated by exactly one cycle with mux_sel=01, busy=0.
- Reset mid-frame: RST=1 during the 4th DATA cycle with DATA_VALID=1 -> following cycle IDLE, mux_sel=01, busy=0; no frame starts until DATA_VALID is seen after RST deasserts.
